// File: rtl/lcfg_cfg_router.sv
// Config-bus router: registers a master access, forwards it to one of two targets by address bit,
// and bounds the wait with a timeout that completes the access and records a sticky error.
module lcfg_cfg_router #(
  parameter int          SPLIT_BIT  = 15,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] TO_RD_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m_irdy,
  output logic        m_trdy,
  input  logic [15:0] m_addr,
  input  logic        m_write,
  input  logic [31:0] m_wr_data,
  output logic [31:0] m_rd_data,
  output logic [15:0] t_addr,
  output logic        t_write,
  output logic [31:0] t_wr_data,
  output logic        t0_irdy,
  input  logic        t0_trdy,
  input  logic [31:0] t0_rd_data,
  output logic        t1_irdy,
  input  logic        t1_trdy,
  input  logic [31:0] t1_rd_data,
  input  logic        err_clr,
  output logic        err_flag,
  output logic [15:0] err_addr
);

  // state | meaning
  // IDLE  | waiting for a master request
  // FWD   | request forwarded to selected target, counting wait cycles
  // DONE  | one-cycle completion pulse to the master
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    FWD  = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        sel;
  logic [15:0] cnt;
  logic        accept;
  logic        trdy_hit;
  logic        timeout;
  logic        sel_trdy;
  logic [31:0] sel_rd_data;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    trdy_hit    = 1'b0;
    timeout     = 1'b0;
    t0_irdy     = 1'b0;
    t1_irdy     = 1'b0;
    m_trdy      = 1'b0;
    sel_trdy    = sel ? t1_trdy : t0_trdy;
    sel_rd_data = sel ? t1_rd_data : t0_rd_data;
    case (state)
      IDLE: begin
        if (m_irdy) begin
          accept    = 1'b1;
          state_nxt = FWD;
        end
      end
      FWD: begin
        t0_irdy = ~sel;
        t1_irdy = sel;
        if (sel_trdy) begin
          trdy_hit  = 1'b1;
          state_nxt = DONE;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        m_trdy    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel       <= 1'b0;
      cnt       <= 16'd0;
      t_addr    <= 16'd0;
      t_write   <= 1'b0;
      t_wr_data <= 32'd0;
      m_rd_data <= 32'd0;
      err_flag  <= 1'b0;
      err_addr  <= 16'd0;
    end else begin
      if (accept) begin
        t_addr    <= m_addr;
        t_write   <= m_write;
        t_wr_data <= m_wr_data;
        sel       <= m_addr[SPLIT_BIT];
        cnt       <= 16'd0;
      end else if (state == FWD && state_nxt == FWD) begin
        cnt <= cnt + 16'd1;
      end

      if (trdy_hit && !t_write) m_rd_data <= sel_rd_data;
      else if (timeout && !t_write) m_rd_data <= TO_RD_DATA;

      // a timeout in the same cycle as err_clr keeps the flag set
      if (timeout) begin
        err_flag <= 1'b1;
        err_addr <= t_addr;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcfg_cfg_router.sv
// Self-checking bench for lcfg_cfg_router: directed plan cases plus randomized accesses
// against a per-transaction reference model; a second instance covers the disabled timeout.
module tb_lcfg_cfg_router;

  localparam int          TO     = 4;
  localparam logic [31:0] TO_DAT = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_irdy, m_trdy, m_write;
  logic [15:0] m_addr, t_addr, err_addr;
  logic [31:0] m_wr_data, m_rd_data, t_wr_data;
  logic        t_write, t0_irdy, t0_trdy, t1_irdy, t1_trdy, err_clr, err_flag;
  logic [31:0] t0_rd_data, t1_rd_data;

  logic        z_m_irdy, z_m_trdy, z_t_write, z_t0_irdy, z_t0_trdy, z_t1_irdy, z_t1_trdy, z_err_flag;
  logic [15:0] z_t_addr, z_err_addr;
  logic [31:0] z_m_rd_data, z_t_wr_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_rd;
  logic        exp_flag;
  logic [15:0] exp_addr;

  always #5 clk = ~clk;

  lcfg_cfg_router #(.SPLIT_BIT(15), .TIMEOUT(TO), .TO_RD_DATA(TO_DAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_irdy(m_irdy), .m_trdy(m_trdy), .m_addr(m_addr), .m_write(m_write),
    .m_wr_data(m_wr_data), .m_rd_data(m_rd_data),
    .t_addr(t_addr), .t_write(t_write), .t_wr_data(t_wr_data),
    .t0_irdy(t0_irdy), .t0_trdy(t0_trdy), .t0_rd_data(t0_rd_data),
    .t1_irdy(t1_irdy), .t1_trdy(t1_trdy), .t1_rd_data(t1_rd_data),
    .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr)
  );

  lcfg_cfg_router #(.SPLIT_BIT(15), .TIMEOUT(0), .TO_RD_DATA(TO_DAT)) dut_noto (
    .clk(clk), .reset_n(reset_n),
    .m_irdy(z_m_irdy), .m_trdy(z_m_trdy), .m_addr(m_addr), .m_write(m_write),
    .m_wr_data(m_wr_data), .m_rd_data(z_m_rd_data),
    .t_addr(z_t_addr), .t_write(z_t_write), .t_wr_data(z_t_wr_data),
    .t0_irdy(z_t0_irdy), .t0_trdy(z_t0_trdy), .t0_rd_data(t0_rd_data),
    .t1_irdy(z_t1_irdy), .t1_trdy(z_t1_trdy), .t1_rd_data(t1_rd_data),
    .err_clr(err_clr), .err_flag(z_err_flag), .err_addr(z_err_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Target responds 'delay' FWD cycles after irdy rises; a delay >= TO never answers in time.
  task automatic run_txn(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                         input int delay, input logic [31:0] rd0, input logic [31:0] rd1,
                         input logic clr_at_to);
    logic sel, sel_irdy, oth_irdy, to, done;
    int   irdy_cnt, oth_cnt, exp_cnt;
    sel      = addr[15];
    to       = (delay >= TO);
    exp_cnt  = to ? TO : delay + 1;
    irdy_cnt = 0;
    oth_cnt  = 0;
    done     = 1'b0;
    if (!wr) exp_rd = to ? TO_DAT : (sel ? rd1 : rd0);
    if (to) begin
      exp_flag = 1'b1;
      exp_addr = addr;
    end
    @(negedge clk);
    m_irdy = 1'b1; m_addr = addr; m_write = wr; m_wr_data = wd;
    t0_rd_data = rd0; t1_rd_data = rd1; t0_trdy = 1'b0; t1_trdy = 1'b0;
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      @(negedge clk);
      sel_irdy = sel ? t1_irdy : t0_irdy;
      oth_irdy = sel ? t0_irdy : t1_irdy;
      if (oth_irdy) oth_cnt++;
      if (sel_irdy) begin
        if (irdy_cnt == 0) begin
          chk("t_addr", {16'd0, t_addr}, {16'd0, addr});
          chk("t_write", {31'd0, t_write}, {31'd0, wr});
          chk("t_wr_data", t_wr_data, wd);
        end
        if (sel) begin t1_trdy = (irdy_cnt >= delay); t0_trdy = 1'($urandom); end
        else     begin t0_trdy = (irdy_cnt >= delay); t1_trdy = 1'($urandom); end
        err_clr = clr_at_to && to && (irdy_cnt == TO - 1);
        irdy_cnt++;
      end else if (m_trdy) begin
        done = 1'b1;
        chk("latency", cyc, exp_cnt + 1);
        chk("irdy_cycles", irdy_cnt, exp_cnt);
        chk("m_rd_data", m_rd_data, exp_rd);
        chk("err_flag", {31'd0, err_flag}, {31'd0, exp_flag});
        chk("err_addr", {16'd0, err_addr}, {16'd0, exp_addr});
        m_irdy = 1'b0;
        err_clr = 1'b0;
        t0_trdy = 1'($urandom);
        t1_trdy = 1'($urandom);
      end
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("unsel_irdy_cycles", oth_cnt, 0);
    @(negedge clk);
    chk("m_trdy_pulse", {31'd0, m_trdy}, 32'd0);
    chk("irdy_after", {30'd0, t0_irdy, t1_irdy}, 32'd0);
    chk("rd_hold", m_rd_data, exp_rd);
    t0_trdy = 1'b0;
    t1_trdy = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr  = 1'b0;
    exp_flag = 1'b0;
    chk("err_clr_flag", {31'd0, err_flag}, {31'd0, exp_flag});
    chk("err_clr_addr", {16'd0, err_addr}, {16'd0, exp_addr});
  endtask

  initial begin
    int   n;
    logic z_done;
    reset_n = 1'b0; m_irdy = 1'b0; m_addr = '0; m_write = 1'b0; m_wr_data = '0;
    t0_trdy = 1'b0; t1_trdy = 1'b0; t0_rd_data = '0; t1_rd_data = '0; err_clr = 1'b0;
    z_m_irdy = 1'b0; z_t0_trdy = 1'b0; z_t1_trdy = 1'b0;
    exp_rd = '0; exp_flag = 1'b0; exp_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_trdy", {31'd0, m_trdy}, 32'd0);
    chk("rst_irdy", {30'd0, t0_irdy, t1_irdy}, 32'd0);
    chk("rst_m_rd_data", m_rd_data, 32'd0);
    chk("rst_t_addr", {16'd0, t_addr}, 32'd0);
    chk("rst_t_wr_data", t_wr_data, 32'd0);
    chk("rst_t_write", {31'd0, t_write}, 32'd0);
    chk("rst_err", {15'd0, err_flag, err_addr}, 32'd0);
    reset_n = 1'b1;

    run_txn(16'h0010, 1'b1, 32'h12345678, 2, 32'h0, 32'h0, 1'b0);
    run_txn(16'h8004, 1'b0, 32'h0, 0, 32'h11111111, 32'hCAFEF00D, 1'b0);
    run_txn(16'h0020, 1'b0, 32'h0, 100, 32'h22222222, 32'h33333333, 1'b0);
    run_txn(16'h8030, 1'b0, 32'h0, 100, 32'h44444444, 32'h55555555, 1'b1);
    clear_err();
    run_txn(16'h0024, 1'b0, 32'h0, TO - 1, 32'h66666666, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_txn(16'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 6)),
              $urandom, $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) clear_err();
    end

    run_txn(16'h0044, 1'b0, 32'h0, 100, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    m_irdy = 1'b1; m_addr = 16'h0050; m_write = 1'b0; t0_trdy = 1'b0; t1_trdy = 1'b0;
    @(negedge clk);
    chk("pre_rst_t0_irdy", {31'd0, t0_irdy}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    m_irdy  = 1'b0;
    @(negedge clk);
    exp_rd = '0; exp_flag = 1'b0; exp_addr = '0;
    chk("midrst_irdy", {30'd0, t0_irdy, t1_irdy}, 32'd0);
    chk("midrst_m_trdy", {31'd0, m_trdy}, 32'd0);
    chk("midrst_m_rd_data", m_rd_data, exp_rd);
    chk("midrst_err", {15'd0, err_flag, err_addr}, 32'd0);
    reset_n = 1'b1;
    run_txn(16'h0060, 1'b0, 32'h0, 1, 32'h77777777, 32'h0, 1'b0);

    @(negedge clk);
    z_m_irdy = 1'b1; m_addr = 16'h0040; m_write = 1'b0; t0_rd_data = 32'hA5A55A5A;
    n = 0;
    z_done = 1'b0;
    for (int cyc = 1; cyc <= 1100 && !z_done; cyc++) begin
      @(negedge clk);
      if (z_t0_irdy) begin
        z_t0_trdy = (n >= 1000);
        n++;
      end else if (z_m_trdy) begin
        z_done = 1'b1;
        chk("noto_latency", cyc, 1002);
        chk("noto_irdy_cycles", n, 1001);
        chk("noto_rd_data", z_m_rd_data, 32'hA5A55A5A);
        chk("noto_err_flag", {31'd0, z_err_flag}, 32'd0);
        z_m_irdy  = 1'b0;
        z_t0_trdy = 1'b0;
      end
    end
    chk("noto_done", {31'd0, z_done}, 32'd1);
    @(negedge clk);
    chk("noto_m_trdy_pulse", {31'd0, z_m_trdy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
